jb_prach_fft_scheduler: RTL and testbench
=========================================

Name: jb_prach_fft_scheduler

Overview:
- Shares one PRACH FFT engine between NUM_CAR carrier symbol buffers on a round-robin basis.
- Collects "symbol ready" pulses from each carrier's buffer and programs the FFT length for the granted carrier.
- Issues a read strobe toward that buffer for exactly the programmed number of samples, tags the stream with the carrier id, then waits for FFT completion before the next grant.
- Sits between the per-carrier PRACH symbol buffers and the FFT alignment stage / FFT core.

Parameters:
- NUM_CAR, 4: number of carriers sharing the FFT.
- CAR_ID_BW, 2: width of carrier id; must equal $clog2(NUM_CAR).
- CNT_BW, 12: width of sample counter and FFT length fields (max length 4095).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  clock enable; all state advances only when high.
- car_en  in  NUM_CAR  per-carrier enable (static level).
- sym_rdy  in  NUM_CAR  per-carrier pulse: one full symbol is buffered.
- car_nfft  in  NUM_CAR*CNT_BW  per-carrier FFT length; carrier i occupies bits [i*CNT_BW +: CNT_BW].
- fft_cfg_valid  out  1  FFT config request.
- fft_cfg_nfft  out  CNT_BW  FFT length being configured.
- fft_cfg_ready  in  1  FFT accepted config.
- fft_tready  in  1  FFT can accept a sample this cycle.
- rd_en  out  1  read strobe to the granted carrier buffer.
- rd_sel  out  CAR_ID_BW  granted carrier id; also used as stream tuser.
- rd_last  out  1  high with rd_en on the final sample of the symbol.
- fft_done  in  1  pulse: FFT finished output of the current symbol.
- busy  out  1  state != IDLE.
- pend  out  NUM_CAR  pending-request vector.
- ovf_err  out  NUM_CAR  sticky: sym_rdy arrived while that carrier was already pending.
- cfg_err  out  NUM_CAR  sticky: granted carrier had car_nfft < 2.

Behaviour:
- Reset: state=IDLE; pend=0, ovf_err=0, cfg_err=0, rr_ptr=0, rd_sel=0, counter=0; fft_cfg_valid=0, rd_en=0, rd_last=0, busy=0.
- Pending tracking (per carrier i, each clk_en cycle):
  - sym_rdy[i] & car_en[i] sets pend[i]; if pend[i] was already 1, also set ovf_err[i].
  - !car_en[i] clears pend[i], except for the carrier currently in STREAM.
  - Grant-clear and a new sym_rdy on the same carrier in the same cycle: set wins.
- Arbitration in IDLE: select the first set pend bit searching upward from rr_ptr, with wrap-around.
  - Register rd_sel and fft_cfg_nfft = car_nfft[sel].
  - Set rr_ptr = sel+1 modulo NUM_CAR.
  - If the selected length < 2: set cfg_err[sel], clear pend[sel], stay IDLE.
  - Otherwise go to CFG. Arbitration costs one cycle.
- CFG: fft_cfg_valid=1, held stable until fft_cfg_ready; on cfg_ready, go to STREAM with counter=0.
- STREAM:
  - rd_en = clk_en & fft_tready, combinational; each rd_en increments counter.
  - rd_last = rd_en & (counter == nfft-1).
  - On rd_last: clear pend[rd_sel] and go to WAIT_DONE.
  - Deasserting car_en[rd_sel] mid-stream does not abort; the symbol completes so the FFT frame stays consistent.
- WAIT_DONE: on fft_done go to IDLE. A fft_done received in any other state is ignored.
- busy and pend are registered state outputs (no extra latency); rd_en and rd_last are combinational from registered state.
- Back-to-back grants: IDLE → CFG takes one cycle after fft_done.
- rd_sel is never changed outside IDLE.
- With clk_en low: no state, counter, pend or error update, and rd_en=0.
- A reset mid-operation returns to the reset values in the next cycle; the partially read symbol is discarded by downstream.

Decomposition:
- Shared package prach_fft_pkg:
  - typedef enum {SCH_IDLE, SCH_CFG, SCH_STREAM, SCH_WAIT_DONE}.
  - localparam PRACH_MIN_NFFT=2.
- One sub-module jb_rr_arbiter (NUM_CAR-wide request vector + pointer → one-hot grant + index + valid), purely combinational, reusable elsewhere.

Test Plan:
1. Single request: car_en=4'b0001, car_nfft[0]=839, sym_rdy[0] pulse, cfg_ready one cycle after valid, tready=1 → exactly 839 rd_en, rd_last on the 839th, rd_sel=0, pend clears, busy until fft_done.
2. Round robin: sym_rdy to carriers 0,1,3 in the same cycle, fft_done 10 cycles after each rd_last → grant order 0,1,3; then new requests on 3 and 0 → order 0,3.
3. Backpressure: nfft=16, fft_tready toggles 1,0,1,0… → 16 rd_en over 31 cycles, counter holds on tready=0, rd_last only on the 16th.
4. Overflow and race: second sym_rdy[2] while pend[2]=1 → ovf_err[2]=1, only one grant; sym_rdy[2] on the rd_last cycle → pend[2] stays 1, second grant follows.
5. Config error and enable drop: car_nfft[1]=1 with a request → cfg_err[1]=1, no cfg_valid, pend[1]=0; car_en[0] dropped mid-STREAM → stream still completes all samples.
6. Reset in STREAM after 100 samples → next cycle all outputs at reset values, rd_en=0; a fresh request then starts from carrier 0.

Source files
------------

// File: rtl/prach_fft_pkg.sv
// prach_fft_pkg: shared types for the PRACH FFT scheduler.
// Holds the scheduler state encoding and the minimum legal FFT length.
package prach_fft_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_CFG,
    SCH_STREAM,
    SCH_WAIT_DONE
  } sch_state_e;

  localparam int PRACH_MIN_NFFT = 2;

endpackage

// File: rtl/jb_rr_arbiter.sv
// jb_rr_arbiter: combinational round-robin pick, search upward from i_ptr.
// Ports: i_req request vector, i_ptr start index; o_gnt one-hot, o_idx, o_vld.
module jb_rr_arbiter #(
  parameter int N      = 4,
  parameter int IDX_BW = 2
) (
  input  logic [N-1:0]      i_req,
  input  logic [IDX_BW-1:0] i_ptr,
  output logic [N-1:0]      o_gnt,
  output logic [IDX_BW-1:0] o_idx,
  output logic              o_vld
);

  logic [IDX_BW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IDX_BW'((int'(i_ptr) + k) % N);
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jb_prach_fft_scheduler.sv
// jb_prach_fft_scheduler: round-robin sharing of one PRACH FFT among carriers.
// In: clk, reset, clk_en, car_en, sym_rdy, car_nfft, fft_cfg_ready,
//   fft_tready, fft_done.
// Out: fft_cfg_valid/nfft, rd_en, rd_sel, rd_last, busy, pend,
//   ovf_err, cfg_err.
module jb_prach_fft_scheduler
  import prach_fft_pkg::*;
#(
  parameter int NUM_CAR   = 4,
  parameter int CAR_ID_BW = 2,
  parameter int CNT_BW    = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [NUM_CAR-1:0]        car_en,
  input  logic [NUM_CAR-1:0]        sym_rdy,
  input  logic [NUM_CAR*CNT_BW-1:0] car_nfft,
  output logic                      fft_cfg_valid,
  output logic [CNT_BW-1:0]         fft_cfg_nfft,
  input  logic                      fft_cfg_ready,
  input  logic                      fft_tready,
  output logic                      rd_en,
  output logic [CAR_ID_BW-1:0]      rd_sel,
  output logic                      rd_last,
  input  logic                      fft_done,
  output logic                      busy,
  output logic [NUM_CAR-1:0]        pend,
  output logic [NUM_CAR-1:0]        ovf_err,
  output logic [NUM_CAR-1:0]        cfg_err
);

  sch_state_e r_state;
  sch_state_e w_state_nxt;

  logic [NUM_CAR-1:0]   r_pend;
  logic [NUM_CAR-1:0]   r_ovf;
  logic [NUM_CAR-1:0]   r_cfg_err;
  logic [CAR_ID_BW-1:0] r_rr_ptr;
  logic [CAR_ID_BW-1:0] r_rd_sel;
  logic [CNT_BW-1:0]    r_nfft;
  logic [CNT_BW-1:0]    r_cnt;

  logic [NUM_CAR-1:0]   w_arb_gnt;
  logic [CAR_ID_BW-1:0] w_arb_idx;
  logic                 w_arb_vld;
  logic [CNT_BW-1:0]    w_sel_nfft;
  logic                 w_arb_go;
  logic                 w_len_bad;
  logic                 w_rd_en;
  logic                 w_rd_last;
  logic [NUM_CAR-1:0]   w_set;
  logic [NUM_CAR-1:0]   w_clr;
  logic [NUM_CAR-1:0]   w_pend_nxt;

  jb_rr_arbiter #(
    .N      (NUM_CAR),
    .IDX_BW (CAR_ID_BW)
  ) u_arb (
    .i_req (r_pend),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_vld (w_arb_vld)
  );

  assign w_sel_nfft = car_nfft[w_arb_idx*CNT_BW +: CNT_BW];
  assign w_len_bad  = w_sel_nfft < CNT_BW'(PRACH_MIN_NFFT);
  assign w_arb_go   = (r_state == SCH_IDLE) && w_arb_vld;

  always_ff @(posedge clk) begin
    if (reset) r_state <= SCH_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clk_en) begin
      unique case (r_state)
        SCH_IDLE:
          if (w_arb_vld && !w_len_bad) w_state_nxt = SCH_CFG;
        SCH_CFG:
          if (fft_cfg_ready) w_state_nxt = SCH_STREAM;
        SCH_STREAM:
          if (w_rd_last) w_state_nxt = SCH_WAIT_DONE;
        SCH_WAIT_DONE:
          if (fft_done) w_state_nxt = SCH_IDLE;
        default:
          w_state_nxt = SCH_IDLE;
      endcase
    end
  end

  always_comb begin
    fft_cfg_valid = (r_state == SCH_CFG);
    busy          = (r_state != SCH_IDLE);
    w_rd_en       = clk_en && fft_tready && (r_state == SCH_STREAM);
    w_rd_last     = w_rd_en && (r_cnt == r_nfft - CNT_BW'(1));
  end

  // The streaming carrier keeps its request through an enable drop so
  // the FFT frame completes; a new sym_rdy beats any clear.
  always_comb begin
    w_set = sym_rdy & car_en;
    w_clr = ~car_en;
    if (r_state == SCH_STREAM) w_clr[r_rd_sel] = 1'b0;
    if (w_rd_last) w_clr[r_rd_sel] = 1'b1;
    if (w_arb_go && w_len_bad) w_clr = w_clr | w_arb_gnt;
    w_pend_nxt = w_set | (r_pend & ~w_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= '0;
      r_ovf     <= '0;
      r_cfg_err <= '0;
      r_rr_ptr  <= '0;
      r_rd_sel  <= '0;
      r_nfft    <= '0;
      r_cnt     <= '0;
    end else if (clk_en) begin
      r_pend <= w_pend_nxt;
      r_ovf  <= r_ovf | (w_set & r_pend);
      if (w_arb_go) begin
        r_rd_sel <= w_arb_idx;
        r_nfft   <= w_sel_nfft;
        if (w_arb_idx == CAR_ID_BW'(NUM_CAR - 1))
          r_rr_ptr <= '0;
        else
          r_rr_ptr <= w_arb_idx + CAR_ID_BW'(1);
        if (w_len_bad) r_cfg_err <= r_cfg_err | w_arb_gnt;
      end
      if (r_state == SCH_CFG && fft_cfg_ready)
        r_cnt <= '0;
      else if (w_rd_en)
        r_cnt <= r_cnt + CNT_BW'(1);
    end
  end

  assign rd_en        = w_rd_en;
  assign rd_last      = w_rd_last;
  assign rd_sel       = r_rd_sel;
  assign fft_cfg_nfft = r_nfft;
  assign pend         = r_pend;
  assign ovf_err      = r_ovf;
  assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_jb_prach_fft_scheduler.sv
// tb_jb_prach_fft_scheduler: scoreboard bench for the PRACH FFT scheduler.
// Expected grants are queued with the stimulus and checked per handshake.
module tb_jb_prach_fft_scheduler;

  typedef struct {
    int car;
    int nfft;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic [3:0]  car_en = '0;
  logic [3:0]  sym_rdy = '0;
  logic [11:0] nf [4];
  logic [47:0] car_nfft;
  logic        fft_cfg_valid;
  logic [11:0] fft_cfg_nfft;
  logic        fft_cfg_ready = 1'b0;
  logic        fft_tready = 1'b1;
  logic        rd_en;
  logic [1:0]  rd_sel;
  logic        rd_last;
  logic        fft_done = 1'b0;
  logic        busy;
  logic [3:0]  pend;
  logic [3:0]  ovf_err;
  logic [3:0]  cfg_err;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  exp_t cur;
  bit   strm = 0;
  bit   vprev = 0;
  int   s_n = 0;
  int   s_cyc = 0;
  int   dcnt = 0;
  int   tmode = 0;

  assign car_nfft = {nf[3], nf[2], nf[1], nf[0]};

  always #5 clk = ~clk;

  jb_prach_fft_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .car_en        (car_en),
    .sym_rdy       (sym_rdy),
    .car_nfft      (car_nfft),
    .fft_cfg_valid (fft_cfg_valid),
    .fft_cfg_nfft  (fft_cfg_nfft),
    .fft_cfg_ready (fft_cfg_ready),
    .fft_tready    (fft_tready),
    .rd_en         (rd_en),
    .rd_sel        (rd_sel),
    .rd_last       (rd_last),
    .fft_done      (fft_done),
    .busy          (busy),
    .pend          (pend),
    .ovf_err       (ovf_err),
    .cfg_err       (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor at negedge, FFT-side responder just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        strm  = 0;
        dcnt  = 0;
        vprev = 0;
      end else begin
        if (strm) begin
          chk("rd_sel", rd_sel, cur.car);
          if (!clk_en) chk("rd_en_gate", rd_en, 0);
          if (rd_en) begin
            s_n++;
            chk("rd_last", rd_last, s_n == cur.nfft);
            if (rd_last) begin
              chk("stream_cyc", s_cyc + 1, cur.cyc);
              strm = 0;
              dcnt = 10;
            end
          end
          s_cyc++;
        end else if (rd_en) begin
          chk("rd_en_idle", rd_en, 0);
        end
        if (dcnt > 0) chk("busy_wd", busy, 1);
        if (fft_cfg_valid && fft_cfg_ready && clk_en) begin
          chk("grant_q", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            chk("grant_car", rd_sel, cur.car);
            chk("grant_nfft", fft_cfg_nfft, cur.nfft);
            strm  = 1;
            s_n   = 0;
            s_cyc = 0;
          end
        end
        vprev = fft_cfg_valid;
      end
      @(posedge clk);
      #1;
      fft_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        fft_done = (dcnt == 0);
      end
      fft_cfg_ready = vprev && fft_cfg_valid && !fft_cfg_ready;
      fft_tready = (tmode == 0) || !strm || !s_cyc[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    sym_rdy = m;
    tick();
    sym_rdy = '0;
  endtask

  task automatic push(input int c, input int n, input int cy);
    exp_t e;
    e.car  = c;
    e.nfft = n;
    e.cyc  = cy;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || busy || strm || dcnt != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_to", n < budget, 1);
  endtask

  task automatic wait_samples(input int k);
    int n = 0;
    while (!(strm && s_n >= k) && n < 5000) begin
      tick();
      n++;
    end
    chk("samp_to", n < 5000, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_cfgerr", cfg_err, 0);
    chk("rst_valid", fft_cfg_valid, 0);
    chk("rst_nfft", fft_cfg_nfft, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_sel", rd_sel, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nf[0] = 12'd839;
    nf[1] = 12'd20;
    nf[2] = 12'd40;
    nf[3] = 12'd33;
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    // 1: single request
    car_en = 4'b0001;
    push(0, 839, 839);
    pulse(4'b0001);
    chk("t1_pend", pend, 4'b0001);
    chk("t1_busy0", busy, 0);
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_valid", fft_cfg_valid, 1);
    chk("t1_nfft", fft_cfg_nfft, 839);
    chk("t1_sel", rd_sel, 0);
    wait_idle(2000);
    chk("t1_pend_clr", pend, 0);

    // 2: round robin
    do_reset();
    car_en = 4'b1111;
    nf[0]  = 12'd24;
    push(0, 24, 24);
    push(1, 20, 20);
    push(3, 33, 33);
    pulse(4'b1011);
    wait_idle(2000);
    push(0, 24, 24);
    push(3, 33, 33);
    pulse(4'b1001);
    wait_idle(2000);
    chk("t2_pend", pend, 0);

    // 3: backpressure
    nf[0] = 12'd16;
    tmode = 1;
    push(0, 16, 31);
    pulse(4'b0001);
    wait_idle(500);
    tmode = 0;

    // 4: overflow and rd_last race
    push(2, 40, 40);
    sym_rdy = 4'b0100;
    tick();
    tick();
    sym_rdy = '0;
    chk("t4_ovf", ovf_err, 4'b0100);
    wait_idle(500);
    chk("t4_pend", pend, 0);
    push(2, 40, 40);
    push(2, 40, 40);
    pulse(4'b0100);
    begin
      int n = 0;
      while (!rd_last && n < 500) begin
        tick();
        n++;
      end
      chk("t4_last_to", n < 500, 1);
    end
    pulse(4'b0100);
    chk("t4_race_pend", pend[2], 1);
    chk("t4_race_busy", busy, 1);
    wait_idle(1000);
    chk("t4_pend2", pend, 0);

    // 5: config error, minimum length, enable drop
    nf[1] = 12'd1;
    pulse(4'b0010);
    repeat (3) tick();
    chk("t5_cfgerr", cfg_err, 4'b0010);
    chk("t5_pend", pend, 0);
    chk("t5_busy", busy, 0);
    nf[1] = 12'd2;
    push(1, 2, 2);
    pulse(4'b0010);
    wait_idle(500);
    nf[0] = 12'd64;
    push(0, 64, 64);
    pulse(4'b0001);
    wait_samples(10);
    car_en = 4'b1110;
    wait_idle(500);
    chk("t5_pend_drop", pend, 0);
    pulse(4'b0001);
    tick();
    chk("t5_dis_pend", pend, 0);
    chk("t5_dis_busy", busy, 0);
    car_en = 4'b1111;

    // 7: clock enable stall mid-stream
    nf[0] = 12'd8;
    push(0, 8, 11);
    pulse(4'b0001);
    wait_samples(2);
    clk_en = 1'b0;
    repeat (3) tick();
    clk_en = 1'b1;
    wait_idle(500);

    // 6: reset mid-stream, then restart from carrier 0
    nf[1] = 12'd139;
    push(1, 139, 139);
    pulse(4'b0010);
    wait_samples(100);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    nf[2] = 12'd20;
    push(0, 8, 8);
    push(2, 20, 20);
    pulse(4'b0101);
    wait_idle(1000);
    chk("t6_pend", pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
